// File: rtl/alu_logic_resp.sv
// alu_logic_resp: registered responder for the 64-bit ALU logic unit.
// It computes AND/OR/XOR/NOT for each accepted request and stores the result
// in a 2-entry FIFO. Each entry holds {tag, y, zero}. Responses leave over a
// valid/ready channel in acceptance order. in_ready depends only on registered
// state, so out_ready has no combinational path to in_ready.
module alu_logic_resp #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOT = 2'b11
   } op_e;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] y;
      logic             zero;
   } entry_t;

   entry_t           mem_q [2];
   entry_t           head;
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic [WIDTH-1:0] result;
   logic             push, pop;

   // Handshakes: the buffer accepts while not full and offers while not empty.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Bitwise logic result for the incoming request; NOT ignores operand B.
   always_comb begin
      // NOTE: every variable written here gets a default first, so a missed branch
      // cannot leave a latch behind.
      result = '0;
      case (op_e'(in_op))
         OP_AND:  result = in_a & in_b;
         OP_OR:   result = in_a | in_b;
         OP_XOR:  result = in_a ^ in_b;
         OP_NOT:  result = ~in_a;
         default: result = '0;
      endcase
   end

   // Next-state for occupancy, pointers and the completed-response counter.
   always_comb begin
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      done_cnt_d = done_cnt_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop) begin
         rd_ptr_d   = ~rd_ptr_q;
         done_cnt_d = done_cnt_q + CNT_W'(1);
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every register
         // samples its pre-edge value and the result does not depend on evaluation order.
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   // Entry storage. The written entry takes the tag, the result and the zero flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this storage has only two entries and the outputs must read zero
         // after reset, so it is cleared here. A larger FIFO would normally leave
         // its memory unreset.
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= '{tag: in_tag, y: result, zero: ~|result};
      end
   end

   // The head entry drives the response outputs straight from registers.
   assign head     = mem_q[rd_ptr_q];
   assign out_y    = head.y;
   assign out_zero = head.zero;
   assign out_tag  = head.tag;
   assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_alu_logic_resp.sv
// Self-checking bench for alu_logic_resp. Stimulus pushes expected responses
// into a scoreboard queue, and a monitor pops them as the DUT delivers.
// The counter is 4 bits wide here, so the wrap case stays short.
module tb_alu_logic_resp;

   localparam int WIDTH = 64;
   localparam int TAG_W = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [1:0]       in_op = 2'b00;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_y;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;
   logic [CNT_W-1:0] done_cnt;

   typedef struct {
      logic [WIDTH-1:0] y;
      logic             zero;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             sb [$];
   logic [CNT_W-1:0] exp_done;
   int               checks = 0;
   int               errors = 0;

   alu_logic_resp #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_zero  (out_zero),
      .out_tag   (out_tag),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [1:0] op);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // Monitor: sample mid-cycle, pop and compare on each response, and push on each accept.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb.delete();
         exp_done = '0;
      end else begin
         check("done_cnt", 64'(done_cnt), 64'(exp_done));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_resp", 64'(1), 64'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("resp_y", out_y, e.y);
               check("resp_zero", 64'(out_zero), 64'(e.zero));
               check("resp_tag", 64'(out_tag), 64'(e.tag));
            end
            exp_done = exp_done + 1'b1;
         end
         if (in_valid && in_ready) begin
            exp_t n;
            n.y    = model(in_a, in_b, in_op);
            n.zero = ~|n.y;
            n.tag  = in_tag;
            sb.push_back(n);
         end
      end
   end

   // Wait until the current request is accepted. Returns the number of cycles taken.
   task automatic wait_accept(output int cycles);
      logic acc;
      cycles = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         cycles++;
         if (acc) return;
      end
      check("accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_tag   = tag;
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] op, input logic [TAG_W-1:0] tag, output int cycles);
      drive(a, b, op, tag);
      wait_accept(cycles);
   endtask

   task automatic drain();
      for (int i = 0; i < 50; i++) begin
         if (sb.size() == 0 && !out_valid) break;
         @(posedge clk);
         #1;
      end
      check("drain_empty", 64'(sb.size()), 64'(0));
      check("drain_valid", 64'(out_valid), 64'(0));
   endtask

   initial begin
      int               cyc;
      logic [WIDTH-1:0] held_y;

      // Reset state, while reset is still held.
      #3;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_y", out_y, 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      check("rst_out_zero", 64'(out_zero), 64'(0));
      check("rst_done_cnt", 64'(done_cnt), 64'(0));
      #4 rst_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      // Single AND with a zero result. The response is visible the cycle after acceptance.
      out_ready = 1'b1;
      send(64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 2'b00, 4'd1, cyc);
      in_valid = 1'b0;
      check("and_valid", 64'(out_valid), 64'(1));
      check("and_y", out_y, 64'h0);
      check("and_zero", 64'(out_zero), 64'(1));
      check("and_tag", 64'(out_tag), 64'(1));
      @(posedge clk);
      #1;
      check("and_done_cnt", 64'(done_cnt), 64'(1));

      // Mixed operations back to back.
      send(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 2'b00, 4'd2, cyc);
      check("mixed_and_y", out_y, 64'h0224422882244220);
      send(64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 2'b10, 4'd3, cyc);
      check("mixed_xor_y", out_y, 64'hFFFFFFFFFFFFFFFF);
      send(64'h0, 64'h1234, 2'b11, 4'd4, cyc);
      check("mixed_not_y", out_y, 64'hFFFFFFFFFFFFFFFF);
      send(64'hA5A5000000000000, 64'h000000000000005A, 2'b01, 4'd5, cyc);
      in_valid = 1'b0;
      drain();

      // Backpressure: two accepts fill the buffer, and the third request is held.
      out_ready = 1'b0;
      send(64'hDEADBEEF00000000, 64'hFFFF0000FFFF0000, 2'b00, 4'd1, cyc);
      send(64'h1111, 64'h2222, 2'b01, 4'd2, cyc);
      check("bp_full_ready", 64'(in_ready), 64'(0));
      held_y = out_y;
      check("bp_head_y", held_y, 64'hDEAD000000000000);
      drive(64'h3, 64'h5, 2'b10, 4'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_y_stable", out_y, held_y);
         check("bp_tag_stable", 64'(out_tag), 64'(1));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_accept(cyc);
      in_valid = 1'b0;
      drain();

      // Steady stream: simultaneous push and pop keeps one entry buffered with no bubbles.
      for (int i = 0; i < 8; i++) begin
         send(64'(i) * 64'h0101010101010101, 64'hFF00FF00FF00FF00, 2'(i), 4'(i + 6), cyc);
         check("stream_no_bubble", 64'(cyc), 64'(1));
         check("stream_valid", 64'(out_valid), 64'(1));
         check("stream_in_ready", 64'(in_ready), 64'(1));
      end
      in_valid = 1'b0;
      drain();

      // Reset mid-operation with two entries buffered.
      out_ready = 1'b0;
      send(64'h1, 64'h1, 2'b00, 4'd10, cyc);
      send(64'h2, 64'h3, 2'b01, 4'd11, cyc);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'(0));
      check("mid_rst_done_cnt", 64'(done_cnt), 64'(0));
      #1 rst_n = 1'b1;
      #0;
      check("mid_rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(64'hFFFF, 64'h00FF, 2'b00, 4'd9, cyc);
      in_valid = 1'b0;
      check("fresh_tag", 64'(out_tag), 64'(9));
      check("fresh_y", out_y, 64'h00FF);
      drain();
      check("fresh_done_cnt", 64'(done_cnt), 64'(1));

      // Counter wrap: 16 more responses bring the total to 17, so a 4-bit counter reads 1.
      for (int i = 0; i < 16; i++) begin
         send(64'(i + 1), 64'hF, 2'b10, 4'(i), cyc);
      end
      in_valid = 1'b0;
      drain();
      check("wrap_done_cnt", 64'(done_cnt), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global bound so the bench cannot hang.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
